// File: rtl/display_pkg.sv
// Shared display-path types and constants for the binary-to-BCD converter and
// the downstream 7-segment decoders.
package display_pkg;

  localparam int unsigned BIN_W      = 20;
  localparam int unsigned BCD_DIGITS = 6;
  localparam int unsigned BCD_MAX    = 999999;

  typedef logic [3:0] bcd_digit_t;
  typedef bcd_digit_t [BCD_DIGITS-1:0] bcd_vec_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  // Largest value representable in n decimal digits (10**n - 1).
  function automatic int unsigned pow10_minus1(input int unsigned n);
    int unsigned p;
    p = 1;
    for (int unsigned i = 0; i < n; i++) p = p * 10;
    return p - 1;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble correction cell: a BCD digit >= 5 gets +3 so that the
// following left shift carries correctly into the next decimal digit.
//   d_i : current digit
//   d_o : corrected digit (4-bit wrap; legal digits 0..9 never overflow)
module bcd_digit_adj
  import display_pkg::*;
(
  input  bcd_digit_t d_i,
  output bcd_digit_t d_o
);

  assign d_o = (d_i >= 4'd5) ? bcd_digit_t'(d_i + 4'd3) : d_i;

endmodule

// File: rtl/bcd_seq_converter.sv
// Multi-cycle binary-to-BCD converter (shift-add-3). One conversion per
// accepted request; the digit vector stays registered for the display.
//   clk, reset  : clock, asynchronous active-high reset
//   in_valid    : request, accepted when in_valid && in_ready
//   in_ready    : converter idle
//   bin_i       : binary input, sampled on the accepting edge only
//   bcd_o       : registered BCD result, digit k at [4k+3:4k]
//   out_valid   : one-cycle pulse after bcd_o updates
//   overflow_o  : input exceeded MAX_VAL and was clamped
//   digit_en_o  : per-digit display enable
// Optional build macro BCD_LEADING_ZERO_BLANK_EN: blanks leading zero digits
// via digit_en_o; without it digit_en_o is constant all ones.
module bcd_seq_converter
  import display_pkg::*;
#(
  parameter int unsigned N_BITS   = BIN_W,
  parameter int unsigned N_DIGITS = BCD_DIGITS,
  parameter int unsigned MAX_VAL  = pow10_minus1(N_DIGITS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_BITS-1:0]     bin_i,
  output logic [4*N_DIGITS-1:0] bcd_o,
  output logic                  out_valid,
  output logic                  overflow_o,
  output logic [N_DIGITS-1:0]   digit_en_o
);

  localparam int unsigned ACC_W = 4 * N_DIGITS;
  localparam int unsigned CNT_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  conv_state_t        state_q;
  logic [N_BITS-1:0]  shift_q;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_q;
  logic [ACC_W-1:0]   bcd_q;
  logic               ovf_out_q;

  logic               sat_c;
  logic [N_BITS-1:0]  load_d;
  logic [ACC_W-1:0]   acc_adj;
  logic [ACC_W-1:0]   acc_d;
  logic               unused_acc_msb;

  // Clamp out-of-range inputs to the display ceiling.
  assign sat_c  = 32'(bin_i) > MAX_VAL;
  assign load_d = sat_c ? N_BITS'(MAX_VAL) : bin_i;

  // Add-3 correction on every digit, then shift {acc,shift} left by one.
  for (genvar g = 0; g < N_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_i (acc_q[4*g +: 4]),
      .d_o (acc_adj[4*g +: 4])
    );
  end

  assign acc_d = {acc_adj[ACC_W-2:0], shift_q[N_BITS-1]};
  // Top accumulator bit is shifted out; clamping guarantees it is zero.
  assign unused_acc_msb = acc_adj[ACC_W-1];

`ifdef BCD_LEADING_ZERO_BLANK_EN
  logic [N_DIGITS-1:0] en_q;
  logic [N_DIGITS-1:0] en_d;
  logic                seen_c;

  // Digit k is lit iff it or any more significant digit is nonzero; digit 0 always lit.
  always_comb begin
    en_d   = '0;
    seen_c = 1'b0;
    for (int k = int'(N_DIGITS) - 1; k >= 0; k--) begin
      seen_c  = seen_c | (acc_d[4*k +: 4] != 4'd0);
      en_d[k] = seen_c;
    end
    en_d[0] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q <= '1;
    end else if (state_q == SHIFT && cnt_q == '0) begin
      en_q <= en_d;
    end
  end

  assign digit_en_o = en_q;
`else
  assign digit_en_o = '1;
`endif

  // Conversion FSM with its datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      bcd_q     <= '0;
      ovf_out_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            shift_q <= load_d;
            ovf_q   <= sat_c;
            acc_q   <= '0;
            cnt_q   <= CNT_W'(N_BITS - 1);
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          acc_q   <= acc_d;
          shift_q <= shift_q << 1;
          cnt_q   <= cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            bcd_q     <= acc_d;
            ovf_out_q <= ovf_q;
            state_q   <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign bcd_o      = bcd_q;
  assign overflow_o = ovf_out_q;

endmodule
